// File: rtl/mem_unit.sv
// Memory stage of the 16-bit WISC pipeline: loads/stores over a req/ack handshake, R15 call/ret
// stack push/pop, and a registered one-cycle writeback bundle.
module mem_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        mem_ready,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        mem_to_reg_in,
  input  logic        call_in,
  input  logic        ret_future_in,
  input  logic [3:0]  reg_rd_in,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] sw_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [3:0]  wb_reg_rd,
  output logic [15:0] wb_data,
  output logic        ret_wb,
  output logic [15:0] PC_stack_pointer,
  output logic        mem_err
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic [2:0] {OpPass, OpLoad, OpStore, OpPush, OpPop, OpIllegal} op_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  function automatic op_e classify(input logic call, input logic ret, input logic rd,
                                   input logic wr);
    if (call && ret) return OpIllegal;
    if (call)        return OpPush;
    if (ret)         return OpPop;
    if (rd && wr)    return OpIllegal;
    if (wr)          return OpStore;
    if (rd)          return OpLoad;
    return OpPass;
  endfunction

  state_e      state_q, state_d;
  op_e         kind_q, kind_d;
  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;
  logic [3:0]  rd_q, rd_d;
  logic [15:0] alu_q, alu_d;
  logic [15:0] sw_q, sw_d;
  logic [15:0] cnt_q, cnt_d;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [3:0]  wb_reg_rd_q, wb_reg_rd_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        ret_wb_q, ret_wb_d;
  logic [15:0] pc_q, pc_d;
  logic        mem_err_q, mem_err_d;

  // Values feeding the response bundle: live inputs in IDLE, the latched operation otherwise
  op_e         src_kind;
  logic        src_rw, src_m2r, load_resp, timed_out;
  logic [3:0]  src_rd;
  logic [15:0] src_alu;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    rw_d      = rw_q;
    m2r_d     = m2r_q;
    rd_d      = rd_q;
    alu_d     = alu_q;
    sw_d      = sw_q;
    cnt_d     = '0;
    load_resp = 1'b0;
    timed_out = 1'b0;

    src_kind = kind_q;
    src_rw   = rw_q;
    src_m2r  = m2r_q;
    src_rd   = rd_q;
    src_alu  = alu_q;

    unique case (state_q)
      StIdle: begin
        src_kind = classify(call_in, ret_future_in, MemRead_in, MemWrite_in);
        src_rw   = RegWrite_in;
        src_m2r  = mem_to_reg_in;
        src_rd   = reg_rd_in;
        src_alu  = alu_result_in;
        if (ex_valid) begin
          kind_d = src_kind;
          rw_d   = RegWrite_in;
          m2r_d  = mem_to_reg_in;
          rd_d   = reg_rd_in;
          alu_d  = alu_result_in;
          sw_d   = sw_data_in;
          if (src_kind == OpPass || src_kind == OpIllegal) begin
            state_d   = StResp;
            load_resp = 1'b1;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (dmem_ack) begin
          state_d   = StResp;
          load_resp = 1'b1;
        end else if (cnt_q == TimeoutLast) begin
          state_d   = StResp;
          load_resp = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    ret_wb_d       = 1'b0;
    mem_err_d      = 1'b0;
    wb_reg_rd_d    = wb_reg_rd_q;
    wb_data_d      = wb_data_q;
    pc_d           = pc_q;
    if (load_resp) begin
      if (timed_out || src_kind == OpIllegal) begin
        mem_err_d = 1'b1;
      end else begin
        wb_valid_d     = 1'b1;
        wb_reg_write_d = src_rw;
        wb_reg_rd_d    = src_rd;
        wb_data_d      = src_alu;
        unique case (src_kind)
          OpLoad: if (src_m2r) wb_data_d = dmem_rdata;
          OpPush: begin
            wb_reg_write_d = 1'b1;
            wb_reg_rd_d    = 4'd15;
          end
          OpPop: begin
            wb_reg_write_d = 1'b1;
            wb_reg_rd_d    = 4'd15;
            wb_data_d      = src_alu + 16'd1;
            ret_wb_d       = 1'b1;
            pc_d           = dmem_rdata;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      kind_q         <= OpPass;
      rw_q           <= 1'b0;
      m2r_q          <= 1'b0;
      rd_q           <= '0;
      alu_q          <= '0;
      sw_q           <= '0;
      cnt_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_reg_rd_q    <= '0;
      wb_data_q      <= '0;
      ret_wb_q       <= 1'b0;
      pc_q           <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      rw_q           <= rw_d;
      m2r_q          <= m2r_d;
      rd_q           <= rd_d;
      alu_q          <= alu_d;
      sw_q           <= sw_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_reg_rd_q    <= wb_reg_rd_d;
      wb_data_q      <= wb_data_d;
      ret_wb_q       <= ret_wb_d;
      pc_q           <= pc_d;
      mem_err_q      <= mem_err_d;
    end
  end

  // Request is decoded from state so an asynchronous reset drops it immediately
  assign dmem_req         = (state_q == StAccess);
  assign dmem_we          = dmem_req && (kind_q == OpStore || kind_q == OpPush);
  assign dmem_addr        = alu_q;
  assign dmem_wdata       = sw_q;
  assign mem_ready        = (state_q == StIdle);
  assign wb_valid         = wb_valid_q;
  assign wb_reg_write     = wb_reg_write_q;
  assign wb_reg_rd        = wb_reg_rd_q;
  assign wb_data          = wb_data_q;
  assign ret_wb           = ret_wb_q;
  assign PC_stack_pointer = pc_q;
  assign mem_err          = mem_err_q;

endmodule

// File: tb/tb_mem_unit.sv
// Directed self-checking bench for mem_unit with a short access timeout.
module tb_mem_unit;

  logic        clk, rst_n, ex_valid, mem_ready;
  logic        RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in, call_in, ret_future_in;
  logic [3:0]  reg_rd_in;
  logic [15:0] alu_result_in, sw_data_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, ret_wb, mem_err;
  logic [3:0]  wb_reg_rd;
  logic [15:0] wb_data, PC_stack_pointer;

  int n_checks = 0;
  int n_errors = 0;

  mem_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_ready(mem_ready),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .mem_to_reg_in(mem_to_reg_in), .call_in(call_in), .ret_future_in(ret_future_in),
    .reg_rd_in(reg_rd_in), .alu_result_in(alu_result_in), .sw_data_in(sw_data_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_reg_rd(wb_reg_rd), .wb_data(wb_data), .ret_wb(ret_wb),
    .PC_stack_pointer(PC_stack_pointer), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single cycle; returns #1 after the accepting edge
  task automatic issue(input logic rw, input logic mw, input logic mr, input logic m2r,
                       input logic call, input logic ret, input logic [3:0] rd,
                       input logic [15:0] alu, input logic [15:0] sw);
    RegWrite_in = rw; MemWrite_in = mw; MemRead_in = mr; mem_to_reg_in = m2r;
    call_in = call; ret_future_in = ret; reg_rd_in = rd; alu_result_in = alu;
    sw_data_in = sw; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; ex_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; mem_to_reg_in = 0;
    call_in = 0; ret_future_in = 0; reg_rd_in = '0; alu_result_in = '0; sw_data_in = '0;
    #12;
    check("rst_ready", mem_ready, 1);
    check("rst_req", dmem_req, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_err", mem_err, 0);
    check("rst_pc", PC_stack_pointer, 0);
    rst_n = 1'b1;
    tick();

    // PASS
    issue(1, 0, 0, 0, 0, 0, 4'd3, 16'h1234, 16'h0);
    check("pass_wbv", wb_valid, 1);
    check("pass_rd", wb_reg_rd, 3);
    check("pass_data", wb_data, 16'h1234);
    check("pass_we", wb_reg_write, 1);
    check("pass_ready_lo", mem_ready, 0);
    check("pass_noreq", dmem_req, 0);
    tick();
    check("pass_ready_hi", mem_ready, 1);
    check("pass_wbv_drop", wb_valid, 0);
    check("pass_hold", wb_data, 16'h1234);

    // LOAD with ack in the third ACCESS cycle
    dmem_rdata = 16'hBEEF;
    issue(1, 0, 1, 1, 0, 0, 4'd5, 16'h0040, 16'h0);
    for (int i = 0; i < 3; i++) begin
      check("ld_req", dmem_req, 1);
      check("ld_addr", dmem_addr, 16'h0040);
      check("ld_we", dmem_we, 0);
      check("ld_ready", mem_ready, 0);
      check("ld_wbv_lo", wb_valid, 0);
      if (i == 2) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    check("ld_wbv", wb_valid, 1);
    check("ld_data", wb_data, 16'hBEEF);
    check("ld_rd", wb_reg_rd, 5);
    check("ld_req_off", dmem_req, 0);
    check("ld_ready_resp", mem_ready, 0);
    tick();
    check("ld_ready_hi", mem_ready, 1);

    // STORE, zero-wait
    issue(0, 1, 0, 0, 0, 0, 4'd2, 16'h0200, 16'hABCD);
    check("st_we", dmem_we, 1);
    check("st_wdata", dmem_wdata, 16'hABCD);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("st_wbv", wb_valid, 1);
    check("st_regwr", wb_reg_write, 0);
    check("st_data", wb_data, 16'h0200);
    tick();

    // PUSH
    issue(1, 0, 0, 0, 1, 0, 4'd15, 16'hEFFF, 16'h0102);
    check("push_we", dmem_we, 1);
    check("push_addr", dmem_addr, 16'hEFFF);
    check("push_wdata", dmem_wdata, 16'h0102);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("push_wbv", wb_valid, 1);
    check("push_rd", wb_reg_rd, 15);
    check("push_data", wb_data, 16'hEFFF);
    check("push_regwr", wb_reg_write, 1);
    check("push_noret", ret_wb, 0);
    tick();

    // POP
    dmem_rdata = 16'h0102;
    issue(1, 0, 0, 0, 0, 1, 4'd15, 16'hEFFF, 16'h0);
    check("pop_we", dmem_we, 0);
    check("pop_addr", dmem_addr, 16'hEFFF);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("pop_ret", ret_wb, 1);
    check("pop_pc", PC_stack_pointer, 16'h0102);
    check("pop_data", wb_data, 16'hF000);
    check("pop_rd", wb_reg_rd, 15);
    check("pop_regwr", wb_reg_write, 1);
    tick();
    check("pop_ret_drop", ret_wb, 0);
    check("pop_pc_hold", PC_stack_pointer, 16'h0102);

    // POP wrap
    dmem_rdata = 16'h1111;
    issue(1, 0, 0, 0, 0, 1, 4'd15, 16'hFFFF, 16'h0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("wrap_data", wb_data, 16'h0000);
    check("wrap_pc", PC_stack_pointer, 16'h1111);
    tick();

    // Timeout, no ack
    issue(1, 0, 1, 1, 0, 0, 4'd6, 16'h0080, 16'h0);
    n = 0;
    for (int i = 0; i < 10 && dmem_req; i++) begin
      n++;
      check("to_wbv_lo", wb_valid, 0);
      tick();
    end
    check("to_req_cycles", n, 4);
    check("to_err", mem_err, 1);
    check("to_wbv", wb_valid, 0);
    check("to_regwr", wb_reg_write, 0);
    tick();
    check("to_err_drop", mem_err, 0);
    check("to_ready", mem_ready, 1);
    issue(1, 0, 0, 0, 0, 0, 4'd7, 16'h0077, 16'h0);
    check("to_next_wbv", wb_valid, 1);
    check("to_next_data", wb_data, 16'h0077);
    tick();

    // Illegal: load and store together
    issue(1, 1, 1, 0, 0, 0, 4'd1, 16'h0300, 16'h0);
    check("ill_noreq", dmem_req, 0);
    check("ill_err", mem_err, 1);
    check("ill_wbv", wb_valid, 0);
    tick();
    check("ill_err_drop", mem_err, 0);
    check("ill_ready", mem_ready, 1);

    // Illegal: call and ret together
    issue(1, 0, 0, 0, 1, 1, 4'd15, 16'h0400, 16'h0);
    check("cr_noreq", dmem_req, 0);
    check("cr_err", mem_err, 1);
    check("cr_ret", ret_wb, 0);
    tick();

    // Reset in the middle of an access
    issue(1, 0, 1, 1, 0, 0, 4'd4, 16'h0500, 16'h0);
    check("rs_req_before", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_req_async", dmem_req, 0);
    check("rs_ready", mem_ready, 1);
    dmem_ack = 1'b1;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rs_no_wbv", wb_valid, 0);
      check("rs_no_req", dmem_req, 0);
      dmem_ack = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- Memory stage of the 16-bit WISC pipeline; consumes the execute stage's forwarded control, alu_result, sw_data, reg_rd and call/ret_future signals.
- Performs data-memory loads and stores over a req/ack handshake with variable latency.
- Implements call pushes and ret pops on the R15 stack, and returns ret_wb plus PC_stack_pointer to the execute stage.
- Presents a registered writeback bundle and stalls the upstream stage while a memory access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles dmem_req is held without dmem_ack before the access is aborted (1..65535).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset; one clock, asynchronous, active-low
ex_valid  in  1  execute stage presents an operation this cycle
mem_ready  out  1  stage can accept an operation (high only in IDLE)
RegWrite_in  in  1  operation writes the register file
MemWrite_in  in  1  store
MemRead_in  in  1  load
mem_to_reg_in  in  1  writeback data comes from memory
call_in  in  1  call push
ret_future_in  in  1  ret pop
reg_rd_in  in  4  destination register (15 for call/ret)
alu_result_in  in  16  address, or non-memory result
sw_data_in  in  16  store data (return PC for call)
dmem_req  out  1  memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  16  memory address
dmem_wdata  out  16  memory write data
dmem_rdata  in  16  memory read data, valid when dmem_ack is high
dmem_ack  in  1  one-cycle completion strobe
wb_valid  out  1  one-cycle pulse: writeback bundle valid
wb_reg_write  out  1  writeback enable
wb_reg_rd  out  4  writeback register
wb_data  out  16  writeback value
ret_wb  out  1  one-cycle pulse: popped return address valid
PC_stack_pointer  out  16  popped return address
mem_err  out  1  one-cycle pulse: illegal operation or timeout

Behaviour:
- Reset: every output is 0 except mem_ready, which is 1. The FSM enters IDLE and the timeout counter clears. Reset asserted mid-access drops dmem_req immediately (asynchronously) and discards the operation with no writeback.
- Accept: ex_valid && mem_ready. All inputs are latched into an operation register on the accepting edge.
- Classification, applied to latched values in priority order:
  - call_in && ret_future_in: ILLEGAL.
  - call_in: PUSH. Write sw_data to alu_result; alu_result is the decremented SP.
  - ret_future_in: POP. Read from alu_result, the current SP.
  - MemRead_in && MemWrite_in: ILLEGAL.
  - MemWrite_in: STORE. Write sw_data to alu_result.
  - MemRead_in: LOAD. Read from alu_result.
  - Otherwise: PASS.
- FSM states are IDLE, ACCESS, RESP.
  - IDLE → ACCESS on accepting a LOAD, STORE, PUSH or POP.
  - IDLE → RESP on accepting a PASS or ILLEGAL.
  - ACCESS: dmem_req = 1, with dmem_we, dmem_addr and dmem_wdata constant for the whole state. dmem_we = 1 for STORE and PUSH. Read data is captured on the edge where dmem_ack = 1, then → RESP.
  - ACCESS timeout: the counter increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES-1 without ack → RESP with the error flag set; dmem_req falls.
  - RESP: outputs are driven for exactly one cycle, then → IDLE. mem_ready is low in ACCESS and RESP.
- RESP outputs:
  - PASS: wb_valid = 1, wb_reg_write = RegWrite_in, wb_reg_rd = reg_rd_in, wb_data = alu_result.
  - LOAD: as PASS, except wb_data = captured rdata when mem_to_reg_in is 1, otherwise alu_result.
  - STORE: wb_valid = 1, wb_reg_write = RegWrite_in, wb_data = alu_result.
  - PUSH: wb_valid = 1, wb_reg_write = 1, wb_reg_rd = 15, wb_data = alu_result (new SP).
  - POP: wb_valid = 1, wb_reg_write = 1, wb_reg_rd = 15, wb_data = alu_result+1 (mod 2^16, so FFFF+1 = 0000). Also ret_wb = 1 and PC_stack_pointer = captured rdata.
  - ILLEGAL or timeout: mem_err = 1, wb_valid = 0, wb_reg_write = 0, ret_wb = 0.
- Output holding: wb_data, wb_reg_rd and PC_stack_pointer hold their values after RESP. wb_valid, wb_reg_write, ret_wb and mem_err are 0 outside RESP.
- Latency: PASS completes 1 cycle after acceptance. A memory operation completes 1 cycle after the ack edge. A zero-wait memory (ack in the first ACCESS cycle) gives 2 cycles.
- Throughput: at most one operation per 2 cycles. There is no acceptance in RESP; ex_valid in RESP is ignored and must be held by the upstream stage.
- dmem_ack outside ACCESS is ignored.

Test Plan:
- PASS: alu_result = 1234, RegWrite = 1, rd = 3, one ex_valid cycle → next cycle wb_valid = 1, wb_reg_rd = 3, wb_data = 1234; mem_ready returns 1 the cycle after.
- LOAD with 3-cycle ack delay: addr 0040, rdata BEEF, mem_to_reg = 1, rd = 5 → dmem_req high 3 cycles with addr 0040 and we = 0 stable; wb_data = BEEF one cycle after ack; mem_ready low throughout.
- PUSH then POP:
  - PUSH with alu_result = EFFF, sw_data = 0102 → write of 0102 to EFFF; wb rd 15 = EFFF.
  - POP with alu_result = EFFF, rdata = 0102 → ret_wb pulse with PC_stack_pointer = 0102; wb rd 15 = F000.
- POP wrap: alu_result = FFFF → wb_data = 0000.
- Timeout with TIMEOUT_CYCLES = 4 and no ack → dmem_req high exactly 4 cycles; mem_err pulses; no wb_valid; next operation accepted normally.
- Illegal and reset:
  - MemRead = MemWrite = 1 → no dmem_req; mem_err pulses the cycle after acceptance.
  - rst_n low during ACCESS → dmem_req drops the same cycle; no wb_valid after release.
